// File: rtl/perf_counter_unit_if.sv
// CSR-side bundle of the performance counter unit: retire strobe, CSR write
// port from writeback, and the registered counter values returned to the CSR file.
interface perf_counter_unit_if #(
  parameter int DWidth = 32,
  parameter int AWidth = 12
);
  logic                  retire_i;
  logic                  csr_we_i;
  logic [1:0]            csr_op_i;
  logic [AWidth-1:0]     csr_addr_i;
  logic [DWidth-1:0]     csr_wdata_i;
  logic [2*DWidth-1:0]   cycle_o;
  logic [2*DWidth-1:0]   instret_o;
  logic [DWidth-1:0]     mcountinhibit_o;

  modport master (
    output retire_i, csr_we_i, csr_op_i, csr_addr_i, csr_wdata_i,
    input  cycle_o, instret_o, mcountinhibit_o
  );

  modport slave (
    input  retire_i, csr_we_i, csr_op_i, csr_addr_i, csr_wdata_i,
    output cycle_o, instret_o, mcountinhibit_o
  );
endinterface

// File: rtl/perf_counter_unit.sv
// Machine performance counters mcycle / minstret / mcountinhibit with CSR
// write, set and clear support; all outputs are driven straight from flops.
module perf_counter_unit #(
  parameter int DWidth = 32,
  parameter int AWidth = 12
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  perf_counter_unit_if.slave bus
);

  localparam int CWidth = 2 * DWidth;

  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_SET   = 2'b01,
    OP_CLEAR = 2'b10,
    OP_NONE  = 2'b11
  } csr_op_e;

  localparam logic [AWidth-1:0] AddrMcycleLo   = AWidth'(12'hB00);
  localparam logic [AWidth-1:0] AddrMcycleHi   = AWidth'(12'hB80);
  localparam logic [AWidth-1:0] AddrMinstretLo = AWidth'(12'hB02);
  localparam logic [AWidth-1:0] AddrMinstretHi = AWidth'(12'hB82);
  localparam logic [AWidth-1:0] AddrInhibit    = AWidth'(12'h320);

  // Only CY (bit 0) and IR (bit 2) exist; everything else is hardwired to zero.
  localparam logic [DWidth-1:0] InhibitMask = DWidth'(5);

  logic [CWidth-1:0] cycle_q, cycle_d;
  logic [CWidth-1:0] instret_q, instret_d;
  logic [DWidth-1:0] inhibit_q, inhibit_d;

  csr_op_e           op;
  logic              wr_valid;
  logic              hit_cy_lo, hit_cy_hi;
  logic              hit_ir_lo, hit_ir_hi;
  logic              hit_inh;
  logic [DWidth-1:0] old_field;
  logic [DWidth-1:0] new_field;

  assign op       = csr_op_e'(bus.csr_op_i);
  assign wr_valid = bus.csr_we_i && (op != OP_NONE);

  // Address decode and selection of the 32-bit field being modified.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    hit_cy_lo = 1'b0;
    hit_cy_hi = 1'b0;
    hit_ir_lo = 1'b0;
    hit_ir_hi = 1'b0;
    hit_inh   = 1'b0;
    old_field = '0;
    if (wr_valid) begin
      case (bus.csr_addr_i)
        AddrMcycleLo: begin
          hit_cy_lo = 1'b1;
          old_field = cycle_q[DWidth-1:0];
        end
        AddrMcycleHi: begin
          hit_cy_hi = 1'b1;
          old_field = cycle_q[CWidth-1:DWidth];
        end
        AddrMinstretLo: begin
          hit_ir_lo = 1'b1;
          old_field = instret_q[DWidth-1:0];
        end
        AddrMinstretHi: begin
          hit_ir_hi = 1'b1;
          old_field = instret_q[CWidth-1:DWidth];
        end
        AddrInhibit: begin
          hit_inh   = 1'b1;
          old_field = inhibit_q;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    new_field = old_field;
    case (op)
      OP_WRITE: new_field = bus.csr_wdata_i;
      OP_SET:   new_field = old_field | bus.csr_wdata_i;
      OP_CLEAR: new_field = old_field & ~bus.csr_wdata_i;
      default:  new_field = old_field;
    endcase
  end

  // A write to either half replaces that half only and suppresses the increment;
  // inhibit is taken from the pre-edge register so a 0x320 write acts a cycle later.
  always_comb begin
    cycle_d = cycle_q;
    if (hit_cy_lo) begin
      cycle_d[DWidth-1:0] = new_field;
    end else if (hit_cy_hi) begin
      cycle_d[CWidth-1:DWidth] = new_field;
    end else if (!inhibit_q[0]) begin
      cycle_d = cycle_q + CWidth'(1);
    end
  end

  always_comb begin
    instret_d = instret_q;
    if (hit_ir_lo) begin
      instret_d[DWidth-1:0] = new_field;
    end else if (hit_ir_hi) begin
      instret_d[CWidth-1:DWidth] = new_field;
    end else if (!inhibit_q[2]) begin
      instret_d = instret_q + CWidth'(bus.retire_i);
    end
  end

  assign inhibit_d = hit_inh ? (new_field & InhibitMask) : inhibit_q;

  // NOTE: state uses non-blocking assignments so all flops update from pre-edge values.
  // NOTE: these are a handful of control registers, so all of them take the async reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cycle_q   <= '0;
      instret_q <= '0;
      inhibit_q <= '0;
    end else begin
      cycle_q   <= cycle_d;
      instret_q <= instret_d;
      inhibit_q <= inhibit_d;
    end
  end

  assign bus.cycle_o         = cycle_q;
  assign bus.instret_o       = instret_q;
  assign bus.mcountinhibit_o = inhibit_q;

endmodule

// File: doc/perf_counter_unit.md
Name: perf_counter_unit

Overview:
Owns the machine performance counters mcycle, minstret and mcountinhibit, and drives their 64-bit values to the CSR read block. Each cycle it increments mcycle, and increments minstret on every retired instruction, unless the count is inhibited. It applies CSR write, set and clear operations from the scalar core's writeback stage. It sits beside the CSR read file in the scalar core; its outputs feed the CSR block's cycle_i and instret_i inputs.

Parameters:
DWidth, 32, CSR data width; counters are DWidth*2 bits
AWidth, 12, CSR address width

Ports:
clk_i  input  1  clock
rst_ni  input  1  asynchronous active-low reset
retire_i  input  1  one instruction retired this cycle
csr_we_i  input  1  CSR write-class operation valid this cycle
csr_op_i  input  2  00 write, 01 set (OR), 10 clear (AND-NOT), 11 reserved (no effect)
csr_addr_i  input  AWidth  target CSR address
csr_wdata_i  input  DWidth  operand (rs1 value or zimm, zero-extended upstream)
cycle_o  output  DWidth*2  current mcycle value (registered)
instret_o  output  DWidth*2  current minstret value (registered)
mcountinhibit_o  output  DWidth  current mcountinhibit value (registered)

Behaviour:
- Reset: asynchronous, active-low. While rst_ni=0: cycle_o=0, instret_o=0, mcountinhibit_o=0. Reset mid-operation discards any in-flight write; counting resumes from 0 on the first rising edge after rst_ni=1.
- All outputs come directly from flops; there is no combinational path from inputs to outputs.
- Address map (all other addresses ignored, no side effects):
  - 0xB00: mcycle[DWidth-1:0]
  - 0xB80: mcycle[2*DWidth-1:DWidth]
  - 0xB02: minstret low half
  - 0xB82: minstret high half
  - 0x320: mcountinhibit; only bit0 (CY) and bit2 (IR) are implemented, all other bits read 0 and ignore writes.
- Write-value computation, with old = current value of the addressed 32-bit field:
  - op 00: new = wdata
  - op 01: new = old | wdata
  - op 10: new = old & ~wdata
  - op 11: no write; the counters still count normally.
- Half-word write: only the addressed half changes, the other half keeps its pre-edge value. There is no carry propagation from the written value.
- Counting per edge, for each counter independently:
  - If a valid write hits either half of the counter this cycle, the next value is the written value and there is no increment that cycle.
  - Else if its inhibit bit is 1, the counter holds.
  - Else mcycle += 1, and minstret += retire_i.
- Inhibit timing: the inhibit bit is sampled from the register value before the edge. A write to 0x320 affects counting from the following cycle onward; the write cycle itself counts per the old inhibit value.
- Arithmetic: full 2*DWidth-bit unsigned add. Carry propagates from the low half into the high half. At 2^64-1, the next increment wraps to 0 with no flag.
- Latency: a write at edge N appears on the output after edge N. The CSR read block adds one register stage, so a software read of a just-written value sees it two cycles after the write edge.
- A write with a set or clear mask of 0 is a legal write: it suppresses that cycle's increment of the addressed counter.

Test Plan:
- Reset release, csr_we_i=0, retire_i=1 held for 10 cycles -> cycle_o=10, instret_o=10, mcountinhibit_o=0; assert rst_ni=0 mid-run -> all outputs 0 immediately (asynchronous).
- Write 0xB00 op00 wdata=0xFFFF_FFFE, then idle 3 cycles -> cycle_o = 0x0000_0000_FFFF_FFFE, then ..._FFFF_FFFF, then 0x0000_0001_0000_0000 (carry into the high half).
- Write 0xB80=0xFFFF_FFFF and 0xB00=0xFFFF_FFFF on separate cycles, then 1 idle cycle -> cycle_o wraps to 0x0000_0000_0000_0000 one cycle after the counter reads 0xFFFF_FFFF_FFFF_FFFF.
- Write 0x320 op01 wdata=0x5 -> from the next cycle cycle_o and instret_o hold their values with retire_i=1. mcountinhibit_o=0x5. Write 0x320 op01 wdata=0xFFFF_FFFF -> mcountinhibit_o=0x5 (unimplemented bits stay 0). Write 0x320 op10 wdata=0x1 -> cycle_o resumes, instret_o stays frozen.
- minstret=0x0000_0000_0000_00F0, write 0xB02 op10 wdata=0xF0 with retire_i=1 in the same cycle -> instret_o=0 (write wins, no increment). Next cycle with retire_i=1 -> instret_o=1.
- csr_op_i=11 to 0xB00, and op00 to unmapped address 0x7C0 -> no change to any register; the counters increment normally.
